pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives stall (hold) and flush (bubble) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and applies taken-branch flushes.
- Sequences data-memory accesses from the MEM stage through a req/ack handshake, with a timeout watchdog.

---
 rtl/pipe_hazard_ctrl_if.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request/acknowledge handshake between the
// hazard controller (master) and the data memory (slave).
interface pipe_hazard_ctrl_if;
    logic dmem_req;
    logic dmem_ack;

    modport master (
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        output dmem_ack
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use, branch flush, dmem wait/timeout.
// Optional perf counters: define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        me_mem_read,
    input  logic        me_mem_write,
    pipe_hazard_ctrl_if.master dmem,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        mem_wb_flush,
    output logic        bus_err,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE =
        CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic mem_access;
    logic mem_stall;
    logic req;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic sel_mem;
    logic sel_br;
    logic sel_lu;

    assign mem_access = me_mem_read | me_mem_write;

    assign rs1_hit = id_use_rs1 & (ex_rd == id_rs1);
    assign rs2_hit = id_use_rs2 & (ex_rd == id_rs2);
    assign load_use = ex_mem_read & (ex_rd != 5'd0)
                    & (rs1_hit | rs2_hit);

    always_comb begin
        mem_stall = 1'b0;
        req       = 1'b0;
        case (state)
            IDLE: begin
                req       = mem_access;
                mem_stall = mem_access & ~dmem.dmem_ack;
            end
            BUSY: begin
                req       = 1'b1;
                mem_stall = ~dmem.dmem_ack;
            end
            ERR: begin
                req       = 1'b0;
                mem_stall = 1'b1;
            end
            default: begin
                req       = 1'b0;
                mem_stall = 1'b0;
            end
        endcase
    end

    // One-hot priority: frozen memory > taken branch > load-use.
    assign sel_mem = rst & mem_stall;
    assign sel_br  = rst & ~mem_stall & ex_branch_taken;
    assign sel_lu  = rst & ~mem_stall & ~ex_branch_taken
                   & load_use;

    assign dmem.dmem_req = rst & req;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        unique case (1'b1)
            sel_mem: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end
            sel_br: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            sel_lu: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_access && !dmem.dmem_ack) begin
                        state <= BUSY;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ERR;
                        bus_err <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ERR: begin
                    state   <= ERR;
                    bus_err <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 32'h0;
            flush_q <= 32'h0;
        end else begin
            if (pc_stall)
                stall_q <= stall_q + 32'd1;
            if (if_id_flush | id_ex_flush)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Inputs change on negedge; outputs sampled 1 time unit later.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        me_mem_read;
    logic        me_mem_write;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_flush;
    logic        ex_mem_stall;
    logic        mem_wb_flush;
    logic        bus_err;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .me_mem_read(me_mem_read),
        .me_mem_write(me_mem_write),
        .dmem(bus.master),
        .pc_stall(pc_stall),
        .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush),
        .bus_err(bus_err),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_rd           = 5'd0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        me_mem_read     = 1'b0;
        me_mem_write    = 1'b0;
        bus.dmem_ack    = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if ({pc_stall, if_id_stall, if_id_flush, id_ex_stall,
             id_ex_flush, ex_mem_stall, mem_wb_flush,
             bus.dmem_req, bus_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outs got %b want 0",
                {pc_stall, if_id_stall, if_id_flush,
                 id_ex_stall, id_ex_flush, ex_mem_stall,
                 mem_wb_flush, bus.dmem_req, bus_err});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        me_mem_read = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.dmem_req !== 1'b1 || ex_mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL busy_pre_rst req %b stall %b want 1 1",
                bus.dmem_req, ex_mem_stall);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.dmem_req, pc_stall, if_id_stall, id_ex_stall,
             ex_mem_stall, mem_wb_flush} !== 6'b0) begin
            errors++;
            $display("FAIL mid_busy_rst got %b want 0",
                {bus.dmem_req, pc_stall, if_id_stall,
                 id_ex_stall, ex_mem_stall, mem_wb_flush});
        end
        @(negedge clk);
        me_mem_read = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0 || bus_err !== 1'b0
            || ex_mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_idle req %b err %b stall %b",
                bus.dmem_req, bus_err, ex_mem_stall);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs2      = 5'd5;
        id_use_rs2  = 1'b1;
        #1;
        checks++;
        if ({pc_stall, if_id_stall, id_ex_flush,
             if_id_flush, id_ex_stall} !== 5'b11100) begin
            errors++;
            $display("FAIL load_use_rs2 got %b want 11100",
                {pc_stall, if_id_stall, id_ex_flush,
                 if_id_flush, id_ex_stall});
        end
        @(negedge clk);
        ex_mem_read = 1'b0;
        me_mem_read = 1'b1;
        bus.dmem_ack = 1'b1;
        #1;
        checks++;
        if ({pc_stall, if_id_stall, id_ex_flush} !== 3'b000) begin
            errors++;
            $display("FAIL load_moved got %b want 000",
                {pc_stall, if_id_stall, id_ex_flush});
        end
        @(negedge clk);
        clear_inputs();
        ex_mem_read = 1'b1;
        id_use_rs2  = 1'b1;
        #1;
        checks++;
        if ({pc_stall, if_id_stall, id_ex_flush} !== 3'b000) begin
            errors++;
            $display("FAIL x0_no_hazard got %b want 000",
                {pc_stall, if_id_stall, id_ex_flush});
        end
        @(negedge clk);
        clear_inputs();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd7;
        id_rs1      = 5'd7;
        id_use_rs1  = 1'b1;
        #1;
        checks++;
        if ({pc_stall, if_id_stall, id_ex_flush} !== 3'b111) begin
            errors++;
            $display("FAIL load_use_rs1 got %b want 111",
                {pc_stall, if_id_stall, id_ex_flush});
        end
        @(negedge clk);
        id_use_rs1 = 1'b0;
        #1;
        checks++;
        if (pc_stall !== 1'b0 || id_ex_flush !== 1'b0) begin
            errors++;
            $display("FAIL rs1_unused got %b%b want 00",
                pc_stall, id_ex_flush);
        end
        @(negedge clk);
        clear_inputs();
        ex_rd       = 5'd9;
        id_rs2      = 5'd9;
        id_use_rs2  = 1'b1;
        #1;
        checks++;
        if (pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL not_a_load got %b want 0", pc_stall);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs();
        ex_mem_read     = 1'b1;
        ex_rd           = 5'd3;
        id_rs1          = 5'd3;
        id_use_rs1      = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if ({if_id_flush, id_ex_flush, pc_stall,
             if_id_stall, id_ex_stall} !== 5'b11000) begin
            errors++;
            $display("FAIL branch_wins got %b want 11000",
                {if_id_flush, id_ex_flush, pc_stall,
                 if_id_stall, id_ex_stall});
        end
    endtask

    task automatic test_wait_states();
        int req_cycles;
        int stall_cycles;
        req_cycles   = 0;
        stall_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            me_mem_write    = 1'b1;
            bus.dmem_ack    = (i == 3);
            ex_branch_taken = (i == 1);
            #1;
            if (bus.dmem_req === 1'b1) req_cycles++;
            if (ex_mem_stall === 1'b1) stall_cycles++;
            checks++;
            if (ex_mem_stall !== (i < 3)
                || mem_wb_flush !== (i < 3)) begin
                errors++;
                $display("FAIL wait_cyc%0d stall %b flush %b",
                    i, ex_mem_stall, mem_wb_flush);
            end
            if (i == 1) begin
                checks++;
                if (if_id_flush !== 1'b0 || id_ex_flush !== 1'b0
                    || id_ex_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL frozen_branch got %b%b%b want 001",
                        if_id_flush, id_ex_flush, id_ex_stall);
                end
            end
        end
        checks++;
        if (req_cycles != 4 || stall_cycles != 3) begin
            errors++;
            $display("FAIL wait_counts req %0d stall %0d want 4 3",
                req_cycles, stall_cycles);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL after_ack_req got %b want 0",
                bus.dmem_req);
        end
        @(negedge clk);
        me_mem_read  = 1'b1;
        bus.dmem_ack = 1'b1;
        #1;
        checks++;
        if (bus.dmem_req !== 1'b1 || ex_mem_stall !== 1'b0
            || pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_wait req %b stall %b want 1 0",
                bus.dmem_req, ex_mem_stall);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL zero_wait_idle got %b want 0",
                bus.dmem_req);
        end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            clear_inputs();
            me_mem_read = 1'b1;
            #1;
            if (bus.dmem_req !== 1'b1 || bus_err !== 1'b0
                || ex_mem_stall !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL busy_window bad cycles %0d want 0", bad);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus_err, bus.dmem_req, pc_stall,
             ex_mem_stall, mem_wb_flush} !== 5'b10111) begin
            errors++;
            $display("FAIL timeout_err got %b want 10111",
                {bus_err, bus.dmem_req, pc_stall,
                 ex_mem_stall, mem_wb_flush});
        end
        repeat (3) @(negedge clk);
        clear_inputs();
        bus.dmem_ack    = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if ({bus_err, bus.dmem_req, if_id_stall,
             if_id_flush} !== 4'b1010) begin
            errors++;
            $display("FAIL err_sticky got %b want 1010",
                {bus_err, bus.dmem_req, if_id_stall,
                 if_id_flush});
        end
        rst = 1'b0;
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (bus_err !== 1'b0 || pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared err %b stall %b want 0 0",
                bus_err, pc_stall);
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        exp_stall = 32'd2;
        exp_flush = 32'd3;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            clear_inputs();
            ex_mem_read = (e < 2);
            ex_rd       = 5'd4;
            id_rs1      = 5'd4;
            id_use_rs1  = 1'b1;
            ex_branch_taken = (e == 2);
            @(negedge clk);
            clear_inputs();
        end
        #1;
        checks++;
        if (perf_stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL perf_stall got %0d want %0d",
                perf_stall_cnt, exp_stall);
        end
        checks++;
        if (perf_flush_cnt !== exp_flush) begin
            errors++;
            $display("FAIL perf_flush got %0d want %0d",
                perf_flush_cnt, exp_flush);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_wait_states();
        test_timeout();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
